// File: rtl/note_sequencer_memory_pkg.sv
// Shared definitions for the note sequencer memory: state encoding,
// default tempo interval and the rest (silence) note word.
package note_sequencer_memory_pkg;

    // Encoding is visible on the state output port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RECORD = 2'b01,
        ST_PLAY   = 2'b10,
        ST_PAUSED = 2'b11
    } seq_state_e;

    // 90 bpm at 16 subdivisions per beat on the system clock.
    localparam int unsigned DEFAULT_INTERVAL = 32'd4166666;

    // Rest word: no octave, no note. Sliced to DATA_WIDTH by users.
    localparam logic [63:0] REST_WORD = '0;

endpackage

// File: rtl/note_sequencer_memory_ram.sv
// Simple dual-port note RAM: one synchronous write port, one synchronous
// read port. Contents are never cleared.
module note_ram #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Asynchronous array look-up feeding the registered read port.
    always_comb begin
        rdata_d = mem[raddr];
    end

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/note_sequencer_memory.sv
// Writable note sequencer: records note words at a tempo interval and plays
// them back with pause/resume, stop and loop support.
module note_sequencer_memory
    import note_sequencer_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_W     = $clog2(DEPTH + 1),
    parameter int unsigned INTERVAL_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rec_start,
    input  logic                  rec_stop,
    input  logic                  play_start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [INTERVAL_W-1:0] interval,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_ready,
    output logic [1:0]            state,
    output logic [ADDR_W-1:0]     count,
    output logic [ADDR_W-1:0]     read_pointer,
    output logic                  full,
    output logic                  done,
    output logic                  wrap
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0]     ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]     LAST_SLOT = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]     FULL_CNT  = ADDR_W'(DEPTH);
    localparam logic [INTERVAL_W-1:0] CNT_ONE   = INTERVAL_W'(1);
    localparam logic [INTERVAL_W-1:0] IV_RESET  = INTERVAL_W'(DEFAULT_INTERVAL);
    localparam logic [DATA_WIDTH-1:0] REST      = DATA_WIDTH'(REST_WORD);

    seq_state_e              state_q,    state_d;
    logic [ADDR_W-1:0]       count_q,    count_d;
    logic [ADDR_W-1:0]       rptr_q,     rptr_d;
    logic [INTERVAL_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [INTERVAL_W-1:0]   iv_q,       iv_d;
    logic                    ordy_q,     ordy_d;
    logic                    done_q,     done_d;
    logic                    wrap_q,     wrap_d;

    logic                    tick;
    logic [INTERVAL_W-1:0]   tick_next;
    logic [INTERVAL_W-1:0]   iv_in;
    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    note_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (RAM_AW)
    ) u_note_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (count_q[RAM_AW-1:0]),
        .wdata (data_in),
        .raddr (rptr_q[RAM_AW-1:0]),
        .rdata (ram_rdata)
    );

    // State, pointers, tick counter, latched interval and output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rptr_q     <= '0;
            tick_cnt_q <= CNT_ONE;
            iv_q       <= IV_RESET;
            ordy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            tick_cnt_q <= tick_cnt_d;
            iv_q       <= iv_d;
            ordy_q     <= ordy_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
        end
    end

    // Command decode (stop > rec_start > play_start > pause), tick and slot advance.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rptr_d     = rptr_q;
        tick_cnt_d = tick_cnt_q;
        iv_d       = iv_q;
        ram_we     = 1'b0;
        done_d     = 1'b0;
        wrap_d     = 1'b0;

        iv_in     = (interval == '0) ? CNT_ONE : interval;
        tick      = (tick_cnt_q == iv_q);
        tick_next = tick ? CNT_ONE : (tick_cnt_q + CNT_ONE);

        if (stop) begin
            state_d    = ST_IDLE;
            rptr_d     = '0;
            tick_cnt_d = CNT_ONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rec_start) begin
                        state_d    = ST_RECORD;
                        count_d    = '0;
                        tick_cnt_d = CNT_ONE;
                        iv_d       = iv_in;
                    end else if (play_start && (count_q != '0)) begin
                        state_d    = ST_PLAY;
                        rptr_d     = '0;
                        tick_cnt_d = CNT_ONE;
                        iv_d       = iv_in;
                    end
                end
                ST_RECORD: begin
                    if (rec_stop) begin
                        state_d    = ST_IDLE;
                        tick_cnt_d = CNT_ONE;
                    end else begin
                        tick_cnt_d = tick_next;
                        if (tick) begin
                            ram_we  = 1'b1;
                            count_d = count_q + ADDR_ONE;
                            if (count_q == LAST_SLOT) begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        tick_cnt_d = tick_next;
                        if (tick) begin
                            if (rptr_q == (count_q - ADDR_ONE)) begin
                                if (loop_en) begin
                                    rptr_d = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    rptr_d  = '0;
                                    done_d  = 1'b1;
                                    state_d = ST_IDLE;
                                end
                            end else begin
                                rptr_d = rptr_q + ADDR_ONE;
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (play_start) begin
                        state_d = ST_PLAY;
                    end
                end
            endcase
        end
    end

    // Output flags and port drive; ready only once PLAY has lasted a full cycle,
    // so it lines up with the one-cycle RAM read latency.
    always_comb begin
        ordy_d       = (state_q == ST_PLAY) && (state_d == ST_PLAY);
        data_out     = ordy_q ? ram_rdata : REST;
        output_ready = ordy_q;
        state        = state_q;
        count        = count_q;
        read_pointer = rptr_q;
        full         = (count_q == FULL_CNT);
        done         = done_q;
        wrap         = wrap_q;
    end

endmodule
